// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined adder/subtractor with valid/ready, flags and optional saturation
// Carry chain split into STAGES ripple segments; operands ride along so later stages can finish the sum.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] p_a [STAGES];
  logic [WIDTH-1:0] p_b [STAGES];
  logic [WIDTH-1:0] p_sum [STAGES];
  logic             p_c [STAGES];
  logic             p_v [STAGES];
  logic             p_sub [STAGES];
  logic             p_sgn [STAGES];

  logic [WIDTH-1:0] n_a [STAGES];
  logic [WIDTH-1:0] n_b [STAGES];
  logic [WIDTH-1:0] n_sum [STAGES];
  logic             n_c [STAGES];
  logic             n_v [STAGES];
  logic             n_sub [STAGES];
  logic             n_sgn [STAGES];

  logic [WIDTH-1:0] src_a, src_b, src_sum;
  logic             src_c, src_v, src_sub, src_sgn;
  logic [SEG:0]     seg_sum;
  logic             adv;

  assign out_valid = p_v[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Stage k adds segment k; stage 0 takes the raw operands, B pre-inverted for subtract.
  always_comb begin
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    src_sub = 1'b0;
    src_sgn = 1'b0;
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_sum = '0;
        src_c   = sub;
        src_v   = in_valid;
        src_sub = sub;
        src_sgn = signed_op;
      end else begin
        src_a   = p_a[(k == 0) ? 0 : k - 1];
        src_b   = p_b[(k == 0) ? 0 : k - 1];
        src_sum = p_sum[(k == 0) ? 0 : k - 1];
        src_c   = p_c[(k == 0) ? 0 : k - 1];
        src_v   = p_v[(k == 0) ? 0 : k - 1];
        src_sub = p_sub[(k == 0) ? 0 : k - 1];
        src_sgn = p_sgn[(k == 0) ? 0 : k - 1];
      end
      seg_sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]} + {{SEG{1'b0}}, src_c};
      n_a[k]   = src_a;
      n_b[k]   = src_b;
      n_sum[k] = src_sum;
      n_sum[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      n_c[k]   = seg_sum[SEG];
      n_v[k]   = src_v;
      n_sub[k] = src_sub;
      n_sgn[k] = src_sgn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        p_a[k]   <= '0;
        p_b[k]   <= '0;
        p_sum[k] <= '0;
        p_c[k]   <= 1'b0;
        p_v[k]   <= 1'b0;
        p_sub[k] <= 1'b0;
        p_sgn[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        p_a[k]   <= n_a[k];
        p_b[k]   <= n_b[k];
        p_sum[k] <= n_sum[k];
        p_c[k]   <= n_c[k];
        p_v[k]   <= n_v[k];
        p_sub[k] <= n_sub[k];
        p_sgn[k] <= n_sgn[k];
      end
    end
  end

  logic s_ovf, u_ovf;

  // p_b already holds ~B for subtract, so the signed test is the same for add and sub.
  always_comb begin
    s_ovf    = (p_a[LAST][WIDTH-1] == p_b[LAST][WIDTH-1]) &&
               (p_sum[LAST][WIDTH-1] != p_a[LAST][WIDTH-1]);
    u_ovf    = p_sub[LAST] ? !p_c[LAST] : p_c[LAST];
    overflow = p_sgn[LAST] ? s_ovf : u_ovf;
    carry    = p_c[LAST];
    result   = p_sum[LAST];
    if (SAT_EN != 0 && overflow) begin
      if (p_sgn[LAST])
        result = p_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        result = p_sub[LAST] ? '0 : '1;
    end
    zero = out_valid && (result == '0);
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed self-checking bench for pipelined_addsub
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        signed_op = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  // 0: STAGES=2 wrap, 1: STAGES=2 saturate, 2: STAGES=1, 3: STAGES=4
  logic        in_ready [4];
  logic        out_valid [4];
  logic        carry [4];
  logic        overflow [4];
  logic        zero [4];
  logic [31:0] result [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(2), .SAT_EN(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
    .sub(sub), .signed_op(signed_op), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(result[0]), .carry(carry[0]), .overflow(overflow[0]), .zero(zero[0]));
  pipelined_addsub #(.WIDTH(32), .STAGES(2), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
    .sub(sub), .signed_op(signed_op), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(result[1]), .carry(carry[1]), .overflow(overflow[1]), .zero(zero[1]));
  pipelined_addsub #(.WIDTH(32), .STAGES(1), .SAT_EN(0)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
    .sub(sub), .signed_op(signed_op), .out_valid(out_valid[2]), .out_ready(out_ready),
    .result(result[2]), .carry(carry[2]), .overflow(overflow[2]), .zero(zero[2]));
  pipelined_addsub #(.WIDTH(32), .STAGES(4), .SAT_EN(0)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .a(a), .b(b),
    .sub(sub), .signed_op(signed_op), .out_valid(out_valid[3]), .out_ready(out_ready),
    .result(result[3]), .carry(carry[3]), .overflow(overflow[3]), .zero(zero[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One isolated operation; r/c/v are raw results, rs is the saturated result.
  task automatic op(input logic [31:0] ai, input logic [31:0] bi, input logic si, input logic gi,
                    input logic [31:0] r, input logic c, input logic v, input logic [31:0] rs);
    @(negedge clk);
    a = ai; b = bi; sub = si; signed_op = gi; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1) begin
        check("s1_valid", 32'(out_valid[2]), 32'd1);
        check("s1_result", result[2], r);
        check("s2_not_early", 32'(out_valid[0]), 32'd0);
      end
      if (k == 2) begin
        check("s2_valid", 32'(out_valid[0]), 32'd1);
        check("s2_result", result[0], r);
        check("s2_carry", 32'(carry[0]), 32'(c));
        check("s2_overflow", 32'(overflow[0]), 32'(v));
        check("s2_zero", 32'(zero[0]), 32'(r == 32'd0));
        check("sat_result", result[1], rs);
        check("sat_carry", 32'(carry[1]), 32'(c));
        check("sat_overflow", 32'(overflow[1]), 32'(v));
        check("sat_zero", 32'(zero[1]), 32'(rs == 32'd0));
      end
      if (k == 4) begin
        check("s4_valid", 32'(out_valid[3]), 32'd1);
        check("s4_result", result[3], r);
      end
    end
  endtask

  function automatic logic [31:0] bp_a(input int i);
    return 32'(i) * 32'h0123_4567 + 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] bp_b(input int i);
    return 32'(i) * 32'd7 + 32'd1;
  endfunction

  initial begin
    int idx, oidx, cyc;
    logic stalled;
    logic [31:0] held;

    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_result", result[d], 32'd0);
    end
    check("rst_carry", 32'(carry[0]), 32'd0);
    check("rst_overflow", 32'(overflow[0]), 32'd0);
    check("rst_zero", 32'(zero[0]), 32'd0);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    rst_n = 1'b1;

    op(32'd25, 32'd30, 1'b0, 1'b0, 32'd55, 1'b0, 1'b0, 32'd55);
    op(32'd100, 32'd50, 1'b1, 1'b1, 32'd50, 1'b1, 1'b0, 32'd50);
    op(32'd0, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
    op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF);
    op(32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h8000_0000);
    op(32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE);
    op(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 32'h0001_0000);

    // Back-pressure stream on the STAGES=2 instance, out_ready pattern 1,0,0 repeating.
    idx = 0; oidx = 0; cyc = 0; stalled = 1'b0; held = '0;
    @(negedge clk);
    while (oidx < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      sub = 1'b0; signed_op = 1'b0;
      if (idx < 8) begin
        in_valid = 1'b1; a = bp_a(idx); b = bp_b(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) check("bp_hold", result[0], held);
      check("bp_in_ready", 32'(in_ready[0]), 32'(!(out_valid[0] && !out_ready)));
      if (out_valid[0] && out_ready) begin
        check("bp_result", result[0], bp_a(oidx) + bp_b(oidx));
        oidx++;
      end
      stalled = out_valid[0] && !out_ready;
      held = result[0];
      if (in_valid && in_ready[0]) idx++;
      cyc++;
      @(negedge clk);
    end
    check("bp_count", 32'(oidx), 32'd8);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with two operations in flight.
    a = 32'd5; b = 32'd6; sub = 1'b0; signed_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'd7; b = 32'd8;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_s2_valid", 32'(out_valid[0]), 32'd1);
    check("pre_rst_s4_valid", 32'(out_valid[3]), 32'd0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check("async_rst_valid", 32'(out_valid[d]), 32'd0);
      check("async_rst_result", result[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) check("no_stale_after_rst", 32'(out_valid[d]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
